// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals of the two-requester ALU arbiter.
// The slave modport is the arbiter's view; master is the requesters/ALU/consumer side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters;
// one operation in flight, result returned on a tagged response channel.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_arbiter_if.slave  bus
);
  localparam logic [OPW-1:0] OP_AND = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0110);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant0;
  logic             grant1;
  logic             op_legal;
  logic             id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;

  // With both valid, the requester not granted last time wins.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
  end

  always_comb begin
    op_legal = (op_q == OP_AND) || (op_q == OP_OR) ||
               (op_q == OP_ADD) || (op_q == OP_SUB);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            id_q       <= grant1;
            last_grant <= grant1;
            a_q        <= grant1 ? bus.req1_a  : bus.req0_a;
            b_q        <= grant1 ? bus.req1_b  : bus.req0_b;
            op_q       <= grant1 ? bus.req1_op : bus.req0_op;
          end
        end
        EXEC: begin
          // Illegal ops still reach the ALU, but its output is discarded.
          result_q <= op_legal ? bus.alu_result : '0;
          zero_q   <= op_legal ? bus.alu_zero   : 1'b1;
          err_q    <= !op_legal;
        end
        default: ;
      endcase
    end
  end

  // Readys are forced low while reset is held, even though the state reads IDLE.
  assign bus.req0_ready = reset_n && (state == IDLE) && grant0;
  assign bus.req1_ready = reset_n && (state == IDLE) && grant1;

  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;
  assign bus.alu_op = op_q;

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: requester queues, an ALU model and a
// response scoreboard, driven by a vector table plus hand-written corner sequences.
module tb_alu_arbiter;
  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    rsp_t        exp;
  } req_t;

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  typedef struct {
    logic id;
    int   cyc;
  } grant_t;

  logic clk;
  logic reset_n;

  alu_arbiter_if #(.WIDTH(32), .OPW(4)) bus ();

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; an illegal op yields a distinctive nonzero value.
  always_comb begin
    bus.alu_result = 32'hDEAD_BEEF;
    case (bus.alu_op)
      4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
      4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
      default: ;
    endcase
    bus.alu_zero = (bus.alu_result == 32'h0);
  end

  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  int     acc_cyc  = 0;
  logic   acc_valid = 1'b0;
  req_t   acc_req;
  logic   prev_valid = 1'b0;
  req_t   q0[$];
  req_t   q1[$];
  rsp_t   sb[$];
  grant_t grants[$];
  vec_t   vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rsp_t ref_op(input logic id, input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.id  = id;
    r.err = 1'b0;
    case (op)
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      4'b0010: r.res = a + b;
      4'b0110: r.res = a - b;
      default: begin r.res = 32'h0; r.err = 1'b1; end
    endcase
    r.zero = (r.res == 32'h0);
    return r;
  endfunction

  task automatic push_req(input logic id, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input rsp_t exp);
    req_t r;
    r.a = a; r.b = b; r.op = op; r.exp = exp;
    if (id) q1.push_back(r);
    else    q0.push_back(r);
  endtask

  task automatic push_auto(input logic id, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    push_req(id, op, a, b, ref_op(id, op, a, b));
  endtask

  // One cycle: drive at negedge, sample 1 time unit later, advance to next negedge.
  task automatic tick();
    rsp_t e;
    bus.req0_valid = (q0.size() > 0);
    if (q0.size() > 0) begin
      bus.req0_a = q0[0].a; bus.req0_b = q0[0].b; bus.req0_op = q0[0].op;
    end
    bus.req1_valid = (q1.size() > 0);
    if (q1.size() > 0) begin
      bus.req1_a = q1[0].a; bus.req1_b = q1[0].b; bus.req1_op = q1[0].op;
    end
    #1;
    chk("ready_exclusive", 32'(bus.req0_ready & bus.req1_ready), 32'h0);
    if (acc_valid && cyc == acc_cyc + 1) begin
      chk("exec_alu_a",  bus.alu_a, acc_req.a);
      chk("exec_alu_b",  bus.alu_b, acc_req.b);
      chk("exec_alu_op", 32'(bus.alu_op), 32'(acc_req.op));
    end
    if (bus.rsp_valid && !prev_valid)
      chk("latency", 32'(cyc - acc_cyc), 32'd2);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id",     32'(bus.rsp_id),   32'(e.id));
        chk("rsp_result", bus.rsp_result,    e.res);
        chk("rsp_zero",   32'(bus.rsp_zero), 32'(e.zero));
        chk("rsp_err",    32'(bus.rsp_err),  32'(e.err));
      end
    end
    prev_valid = bus.rsp_valid;
    if (bus.req0_ready && q0.size() > 0) begin
      acc_req = q0.pop_front();
      sb.push_back(acc_req.exp);
      grants.push_back('{id: 1'b0, cyc: cyc});
      acc_cyc = cyc; acc_valid = 1'b1;
    end else if (bus.req1_ready && q1.size() > 0) begin
      acc_req = q1.pop_front();
      sb.push_back(acc_req.exp);
      grants.push_back('{id: 1'b1, cyc: cyc});
      acc_cyc = cyc; acc_valid = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200)
      chk("drain_timeout", 32'(q0.size() + q1.size() + sb.size()), 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'h0);
    chk({tag, "_req1_ready"}, 32'(bus.req1_ready), 32'h0);
    chk({tag, "_rsp_valid"},  32'(bus.rsp_valid),  32'h0);
    chk({tag, "_rsp_id"},     32'(bus.rsp_id),     32'h0);
    chk({tag, "_rsp_result"}, bus.rsp_result,      32'h0);
    chk({tag, "_rsp_zero"},   32'(bus.rsp_zero),   32'h0);
    chk({tag, "_rsp_err"},    32'(bus.rsp_err),    32'h0);
    chk({tag, "_alu_a"},      bus.alu_a,           32'h0);
    chk({tag, "_alu_b"},      bus.alu_b,           32'h0);
    chk({tag, "_alu_op"},     32'(bus.alu_op),     32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  legal_ops[4];
    rsp_t        r;
    logic [31:0] snap_res;
    logic        snap_id, snap_zero, snap_err;
    int          n;
    int          hs_cyc;

    legal_ops[0] = 4'b0000; legal_ops[1] = 4'b0001;
    legal_ops[2] = 4'b0010; legal_ops[3] = 4'b0110;

    vt[0] = '{id: 1'b0, op: 4'b0010, a: 32'd5,         b: 32'd7,         res: 32'd12,        zero: 1'b0, err: 1'b0};
    vt[1] = '{id: 1'b1, op: 4'b0110, a: 32'd9,         b: 32'd9,         res: 32'd0,         zero: 1'b1, err: 1'b0};
    vt[2] = '{id: 1'b1, op: 4'b0110, a: 32'd0,         b: 32'd1,         res: 32'hFFFF_FFFF, zero: 1'b0, err: 1'b0};
    vt[3] = '{id: 1'b0, op: 4'b1111, a: 32'd3,         b: 32'd4,         res: 32'd0,         zero: 1'b1, err: 1'b1};
    vt[4] = '{id: 1'b0, op: 4'b0010, a: 32'd1,         b: 32'd2,         res: 32'd3,         zero: 1'b0, err: 1'b0};
    vt[5] = '{id: 1'b1, op: 4'b0000, a: 32'h0000_F0F0, b: 32'h0000_FF00, res: 32'h0000_F000, zero: 1'b0, err: 1'b0};
    vt[6] = '{id: 1'b0, op: 4'b0001, a: 32'h0000_0F0F, b: 32'h0000_F000, res: 32'h0000_FF0F, zero: 1'b0, err: 1'b0};
    vt[7] = '{id: 1'b1, op: 4'b0010, a: 32'hFFFF_FFFF, b: 32'd1,         res: 32'd0,         zero: 1'b1, err: 1'b0};
    vt[8] = '{id: 1'b1, op: 4'b0111, a: 32'd8,         b: 32'd8,         res: 32'd0,         zero: 1'b1, err: 1'b1};
    vt[9] = '{id: 1'b0, op: 4'b0110, a: 32'd3,         b: 32'd5,         res: 32'hFFFF_FFFE, zero: 1'b0, err: 1'b0};

    bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 1'b1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    reset_n = 1'b1;

    // Lone req0 ADD: accepted immediately, response two cycles later.
    r = '{id: 1'b0, res: 32'd12, zero: 1'b0, err: 1'b0};
    push_req(1'b0, 4'b0010, 32'd5, 32'd7, r);
    n = cyc;
    tick();
    if (grants.size() == 0) chk("t1_grant_missing", 32'h0, 32'h1);
    else                    chk("t1_accept_cycle", 32'(grants[0].cyc), 32'(n));
    drain();

    // Both requesters valid throughout: grants alternate, 3 cycles apart.
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      push_auto(1'b0, legal_ops[$urandom_range(0, 3)], $urandom, $urandom);
      push_auto(1'b1, legal_ops[$urandom_range(0, 3)], $urandom, $urandom);
    end
    drain();
    if (grants.size() != 8) begin
      chk("t2_grant_count", 32'(grants.size()), 32'd8);
    end else begin
      chk("t2_first_grant", 32'(grants[0].id), 32'h1);
      for (int i = 1; i < 8; i++) begin
        chk("t2_alternate", 32'(grants[i].id), 32'(!grants[i-1].id));
        chk("t2_interval",  32'(grants[i].cyc - grants[i-1].cyc), 32'd3);
      end
    end

    for (int i = 0; i < 10; i++) begin
      r = '{id: vt[i].id, res: vt[i].res, zero: vt[i].zero, err: vt[i].err};
      push_req(vt[i].id, vt[i].op, vt[i].a, vt[i].b, r);
      drain();
    end

    // Consumer stalls for 10 cycles while req1 waits.
    bus.rsp_ready = 1'b0;
    push_auto(1'b0, 4'b0010, 32'd20, 32'd22);
    n = 0;
    while (!bus.rsp_valid && n < 10) begin tick(); n++; end
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    snap_res = bus.rsp_result; snap_id = bus.rsp_id;
    snap_zero = bus.rsp_zero;  snap_err = bus.rsp_err;
    chk("t5_result", snap_res, 32'd42);
    push_auto(1'b1, 4'b0110, 32'd50, 32'd8);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_req1_ready", 32'(bus.req1_ready), 32'h0);
      chk("t5_hold_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t5_hold_result", bus.rsp_result, snap_res);
      chk("t5_hold_meta", {29'h0, bus.rsp_id, bus.rsp_zero, bus.rsp_err},
          {29'h0, snap_id, snap_zero, snap_err});
    end
    bus.rsp_ready = 1'b1;
    hs_cyc = cyc;
    grants.delete();
    drain();
    if (grants.size() == 0) begin
      chk("t5_grant_missing", 32'h0, 32'h1);
    end else begin
      chk("t5_grant_id",  32'(grants[0].id), 32'h1);
      chk("t5_grant_cyc", 32'(grants[0].cyc), 32'(hs_cyc + 1));
    end

    // Reset pulse during EXEC discards the in-flight op.
    push_auto(1'b0, 4'b0010, 32'd1, 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb.delete();
    acc_valid  = 1'b0;
    prev_valid = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    grants.delete();
    push_auto(1'b0, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
    push_auto(1'b1, 4'b0000, 32'hFFFF_0000, 32'h00FF_FF00);
    drain();
    if (grants.size() != 2) begin
      chk("t6_grant_count", 32'(grants.size()), 32'd2);
    end else begin
      chk("t6_first_grant",  32'(grants[0].id), 32'h0);
      chk("t6_second_grant", 32'(grants[1].id), 32'h1);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU (ops: AND, OR, ADD, SUB) between two requesters, e.g. the main datapath and a branch-compare/address unit.
- Round-robin arbitration; valid/ready request handshake per requester.
- The captured request drives the external ALU for one cycle, then the registered result is returned on a shared response channel tagged with requester ID.
- Sits between the requesters and the ALU instance; the ALU itself stays purely combinational.

Parameters:
- WIDTH, 32, operand/result width (must match ALU).
- OPW, 4, ALU operation code width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  WIDTH  operand A, requester 0.
- req0_b  in  WIDTH  operand B, requester 0.
- req0_op  in  OPW  ALU operation code, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_op  out  OPW  to ALU ALUOp.
- alu_result  in  WIDTH  from ALU result.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that issued the response (0/1).
- rsp_result  out  WIDTH  registered ALU result.
- rsp_zero  out  1  registered zero flag.
- rsp_err  out  1  operation code was illegal.

Behaviour:
- Opcodes: AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110. Any other code is illegal.
- FSM states: IDLE, EXEC, RESP.
- Reset (asynchronous, reset_n=0):
  - state=IDLE; last_grant=1, so requester 0 wins first.
  - Operand/op registers = 0, hence alu_a=0, alu_b=0, alu_op=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - req0_ready=0 and req1_ready=0.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, only for the winner, and only when that reqN_valid=1.
  - Winner when only one requester is valid: that requester.
  - Winner when both are valid: the requester that is not last_grant.
  - On the accepting edge: capture a, b, op and id; update last_grant=id; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_a, alu_b, alu_op come directly from the captured registers. They are stable for the whole cycle and hold their value in all other states.
  - On the edge: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_err<=0; go to RESP.
  - Illegal captured op: rsp_result<=0, rsp_zero<=1, rsp_err<=1. The op is still driven to the ALU, but its output is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result, rsp_zero and rsp_err are stable until the handshake.
  - Edge with rsp_ready=1: go to IDLE; rsp_valid deasserts the next cycle.
  - rsp_ready=0 holds the response indefinitely. No new request is accepted (both readys 0).
- Latency:
  - Acceptance edge to rsp_valid = 2 cycles.
  - Minimum issue interval = 3 cycles (IDLE, EXEC, RESP with rsp_ready already high).
- Requester rules:
  - A requester must hold valid and its payload until ready.
  - Payload changes after acceptance have no effect.
- No internal queue; each requester has at most one outstanding operation.
- Reset asserted mid-operation: everything goes immediately to reset values and the in-flight response is discarded. The first grant after reset goes to requester 0.
- Arithmetic: no carry/overflow output. Wrap-around is modulo 2^WIDTH, as produced by the ALU.

Test Plan:
1. Reset, then req0 ADD a=5, b=7 alone -> req0_ready in cycle 0; alu_op=0010 in cycle 1; cycle 2: rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0, rsp_err=0.
2. req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, each 3 cycles apart; rsp_id follows the same order.
3. req1 SUB a=9, b=9 -> rsp_result=0, rsp_zero=1; req1 SUB a=0, b=1 -> rsp_result=32'hFFFFFFFF, rsp_zero=0.
4. req0 op=4'b1111 -> rsp_err=1, rsp_result=0, rsp_zero=1; the next legal op returns rsp_err=0.
5. rsp_ready held 0 for 10 cycles with req1 valid -> response stable, req1_ready stays 0; rsp_ready=1 -> IDLE, then req1 is granted.
6. reset_n pulsed low during EXEC -> all outputs at reset values immediately; after release, a simultaneous req0/req1 grants req0 first.
